// File: rtl/sram_bridge.sv
// sram_bridge: 32-bit CPU data port to 16-bit async SRAM, two halves per word.
// Define SRAM_BRIDGE_SKIP_EN to skip write halves with no enabled bytes.
module sram_bridge #(
   parameter int ADDR_W      = 20,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_out,
   input  logic [15:0]       sram_dq_in,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LO_SETUP,
      LO_STROBE,
      HI_SETUP,
      HI_STROBE,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-2:0]   base_q, base_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         rdata_d;

   logic                rv_d, busy_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [15:0]         dqo_d;
   logic                dq_oe_d;
   logic                ce_d, oe_d, wen_d, ub_d, lb_d;
   logic                hi_d;
   logic [1:0]          half_be;
   logic [15:0]         half_data;

   logic unused_addr;
   assign unused_addr = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

   // Transaction sequencing and latching of the accepted request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = resp_rdata;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = req_we;
               base_d  = req_addr[ADDR_W:2];
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = '0;
`ifdef SRAM_BRIDGE_SKIP_EN
               if (req_we && req_be == 4'b0000)
                  state_d = DONE;
               else if (req_we && req_be[1:0] == 2'b00)
                  state_d = HI_SETUP;
               else
                  state_d = LO_SETUP;
`else
               state_d = LO_SETUP;
`endif
            end
         end
         LO_SETUP: begin
            cnt_d   = '0;
            state_d = LO_STROBE;
         end
         LO_STROBE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!we_q)
                  rdata_d[15:0] = sram_dq_in;
`ifdef SRAM_BRIDGE_SKIP_EN
               if (we_q && be_q[3:2] == 2'b00)
                  state_d = DONE;
               else
                  state_d = HI_SETUP;
`else
               state_d = HI_SETUP;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HI_SETUP: begin
            cnt_d   = '0;
            state_d = HI_STROBE;
         end
         HI_STROBE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!we_q)
                  rdata_d[31:16] = sram_dq_in;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so every pin is a flop
   always_comb begin
      hi_d      = (state_d == HI_SETUP) || (state_d == HI_STROBE);
      half_be   = hi_d ? be_d[3:2] : be_d[1:0];
      half_data = hi_d ? wdata_d[31:16] : wdata_d[15:0];
      busy_d    = (state_d != IDLE);
      rv_d      = 1'b0;
      addr_d    = sram_addr;
      dqo_d     = sram_dq_out;
      dq_oe_d   = 1'b0;
      ce_d      = 1'b1;
      oe_d      = 1'b1;
      wen_d     = 1'b1;
      ub_d      = 1'b1;
      lb_d      = 1'b1;
      unique case (state_d)
         LO_SETUP, HI_SETUP: begin
            addr_d = {base_d, hi_d};
            ce_d   = 1'b0;
            if (we_d) begin
               dq_oe_d = 1'b1;
               dqo_d   = half_data;
            end
         end
         LO_STROBE, HI_STROBE: begin
            addr_d = {base_d, hi_d};
            ce_d   = 1'b0;
            if (we_d) begin
               wen_d   = 1'b0;
               dq_oe_d = 1'b1;
               dqo_d   = half_data;
               ub_d    = ~half_be[1];
               lb_d    = ~half_be[0];
            end else begin
               oe_d = 1'b0;
               ub_d = 1'b0;
               lb_d = 1'b0;
            end
         end
         DONE: begin
            rv_d = 1'b1;
         end
         default: begin
            rv_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         base_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         busy        <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         resp_valid  <= rv_d;
         resp_rdata  <= rdata_d;
         busy        <= busy_d;
         sram_addr   <= addr_d;
         sram_dq_out <= dqo_d;
         sram_dq_oe  <= dq_oe_d;
         sram_ce_n   <= ce_d;
         sram_oe_n   <= oe_d;
         sram_we_n   <= wen_d;
         sram_ub_n   <= ub_d;
         sram_lb_n   <= lb_d;
      end
   end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: W=1 instance with an SRAM model,
// plus a W=2 instance for back-to-back request spacing.
module tb_sram_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;

   logic        resp_valid, busy, dq_oe;
   logic [31:0] resp_rdata;
   logic [19:0] sram_addr;
   logic [15:0] dq_out, dq_in;
   logic        ce_n, oe_n, we_n, ub_n, lb_n;

   logic        resp_valid2, busy2, dq_oe2;
   logic [31:0] resp_rdata2;
   logic [19:0] sram_addr2;
   logic [15:0] dq_out2, dq_in2;
   logic        ce_n2, oe_n2, we_n2, ub_n2, lb_n2;

   logic [15:0] mem [0:31];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] v_ce, v_oe, v_we, v_dqoe, v_ub, v_lb, v_rv, v_busy;
   logic [19:0] l_addr [0:7];

   always #5 clk = ~clk;

   sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
      .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
      .sram_dq_oe(dq_oe), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
   );

   sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .busy(busy2),
      .sram_addr(sram_addr2), .sram_dq_out(dq_out2), .sram_dq_in(dq_in2),
      .sram_dq_oe(dq_oe2), .sram_ce_n(ce_n2), .sram_oe_n(oe_n2),
      .sram_we_n(we_n2), .sram_ub_n(ub_n2), .sram_lb_n(lb_n2)
   );

   assign dq_in  = mem[sram_addr[4:0]];
   assign dq_in2 = {4'hC, sram_addr2[11:0]};

   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         if (!lb_n) mem[sram_addr[4:0]][7:0]  = dq_out[7:0];
         if (!ub_n) mem[sram_addr[4:0]][15:8] = dq_out[15:8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      @(posedge clk); #1;
      req = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      @(posedge clk); #1;
      req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         v_ce[k]   = ce_n;
         v_oe[k]   = oe_n;
         v_we[k]   = we_n;
         v_dqoe[k] = dq_oe;
         v_ub[k]   = ub_n;
         v_lb[k]   = lb_n;
         v_rv[k]   = resp_valid;
         v_busy[k] = busy;
         l_addr[k] = sram_addr;
      end
   endtask

   initial begin
      int rise [0:7];
      int nr, nr1, nrv2;
      logic p1, p2, rv_seen;

      for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
      mem[4] = 16'h1234;
      mem[5] = 16'hABCD;

      // reset held for 3 cycles with a request present
      req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rv", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_dqoe_addr", {11'd0, dq_oe, sram_addr}, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
      req = 1'b0;
      rst = 1'b1;

      // read, W=1
      run_txn(1'b0, 32'h0000_0008, 32'h0, 4'hF);
      for (int k = 0; k < 4; k++)
         chk($sformatf("rd_addr_c%0d", k), {12'd0, l_addr[k]},
             (k < 2) ? 32'd4 : 32'd5);
      chk("rd_ce", {24'd0, v_ce}, 32'hF0);
      chk("rd_oe", {24'd0, v_oe}, 32'hF5);
      chk("rd_we", {24'd0, v_we}, 32'hFF);
      chk("rd_lanes", {16'd0, v_ub, v_lb}, 32'hF5F5);
      chk("rd_rv", {24'd0, v_rv}, 32'h10);
      chk("rd_busy", {24'd0, v_busy}, 32'h1F);
      chk("rd_data", resp_rdata, 32'hABCD_1234);

      // full write
      run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
      chk("wr_we", {24'd0, v_we}, 32'hF5);
      chk("wr_oe", {24'd0, v_oe}, 32'hFF);
      chk("wr_dqoe", {24'd0, v_dqoe}, 32'h0F);
      chk("wr_lanes", {16'd0, v_ub, v_lb}, 32'hF5F5);
      chk("wr_rv", {24'd0, v_rv}, 32'h10);
      chk("wr_mem", {mem[9], mem[8]}, 32'hDEAD_BEEF);
      chk("wr_rdata_kept", resp_rdata, 32'hABCD_1234);

      // single-byte write in the high half
      run_txn(1'b1, 32'h0000_0010, 32'h00AA_0000, 4'h4);
      chk("b4_ub", {24'd0, v_ub}, 32'hFF);
`ifdef SRAM_BRIDGE_SKIP_EN
      chk("b4_lb", {24'd0, v_lb}, 32'hFD);
      chk("b4_we", {24'd0, v_we}, 32'hFD);
      chk("b4_rv", {24'd0, v_rv}, 32'h04);
      chk("b4_busy", {24'd0, v_busy}, 32'h07);
`else
      chk("b4_lb", {24'd0, v_lb}, 32'hF7);
      chk("b4_we", {24'd0, v_we}, 32'hF5);
      chk("b4_rv", {24'd0, v_rv}, 32'h10);
      chk("b4_busy", {24'd0, v_busy}, 32'h1F);
`endif
      chk("b4_mem", {mem[9], mem[8]}, 32'hDEAA_BEEF);

      // reset asserted in cycle 2 of a read
      @(posedge clk); #1;
      req = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_be = 4'hF;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_strobes", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
      chk("mr_rdata", resp_rdata, 32'd0);
      rv_seen = resp_valid;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rv_seen = rv_seen | resp_valid;
      end
      chk("mr_no_rv", {31'd0, rv_seen}, 32'd0);

      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF);
      chk("mr_fresh_rv", {24'd0, v_rv}, 32'h10);
      chk("mr_fresh_data", resp_rdata, 32'hDEAA_BEEF);

      // back-to-back requests, req held high
      @(posedge clk); #1;
      req = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF;
      nr = 0; nr1 = 0; nrv2 = 0; p1 = 1'b0; p2 = 1'b0;
      for (int k = 0; k < 8; k++) rise[k] = -1;
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         if (busy2 && !p2) begin
            if (nr < 8) rise[nr] = k;
            nr++;
         end
         if (busy && !p1) nr1++;
         if (resp_valid2) nrv2++;
         p1 = busy;
         p2 = busy2;
      end
      @(posedge clk); #1;
      req = 1'b0;
      repeat (10) @(negedge clk);
      chk("b2b_first", rise[0], 32'd1);
      chk("b2b_gap1", rise[1] - rise[0], 32'd8);
      chk("b2b_gap2", rise[2] - rise[1], 32'd8);
      chk("b2b_count", nr, 32'd4);
      chk("b2b_resp", nrv2, 32'd3);
      chk("b2b_count_w1", nr1, 32'd5);
      chk("b2b_rdata", resp_rdata2, 32'hC011_C010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
